hbuf_ring_ctrl: RTL and testbench

HBUF_RING_CTRL -- requirements
Module: hbuf_ring_ctrl

---
 rtl/hbuf_ring_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_hbuf_ring_ctrl.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbuf_ring_ctrl.sv
// Ring-buffer page controller: hands staged pages to a DDR3 writer, tracks ring occupancy,
// and services four-phase page-free requests with optional drop-oldest overwrite.
module hbuf_ring_ctrl #(
  parameter int unsigned P_PG_W          = 16,
  parameter int unsigned P_PG_WORDS_LOG2 = 11,
  parameter int unsigned P_ADDR_W        = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [P_PG_W-1:0]   start_pg,
  input  logic [P_PG_W-1:0]   stop_pg,
  input  logic                overwrite,
  input  logic [P_PG_W-1:0]   hwm,
  input  logic                pg_ready,
  output logic                pg_done,
  output logic                pg_req,
  input  logic                pg_ack,
  output logic [P_ADDR_W-1:0] pg_addr,
  input  logic                pg_clr_req,
  input  logic [P_PG_W-1:0]   pg_clr_cnt,
  output logic                pg_clr_ack,
  output logic [P_PG_W-1:0]   rd_pg_num,
  output logic [P_PG_W-1:0]   wr_pg_num,
  output logic [P_PG_W-1:0]   n_used_pgs,
  output logic                empty,
  output logic                full,
  output logic                hwm_flag,
  output logic [31:0]         n_dropped,
  output logic                cfg_err,
  output logic [P_PG_W-1:0]   first_pg,
  output logic [P_PG_W-1:0]   last_pg
);

  localparam int unsigned FullW = P_PG_W + P_PG_WORDS_LOG2;
  localparam logic [P_PG_W-1:0] PgOne = P_PG_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAckLowWait,
    StAdv,
    StFull
  } state_e;

  state_e              state_q;
  logic                en_q;
  logic                clr_req_q;
  logic                clr_pend_q;
  logic [P_PG_W-1:0]   n_alloc_q;

  logic [P_PG_W-1:0]   wr_nxt;
  logic [P_PG_W-1:0]   rd_nxt;
  logic [P_PG_W-1:0]   n_used;
  logic [P_PG_W-1:0]   cnt_clip;
  logic [P_PG_W-1:0]   rd_off;
  logic [P_PG_W:0]     clr_sum;
  logic [P_PG_W:0]     clr_wrap;
  logic [P_PG_W-1:0]   rd_clr;
  logic [P_PG_W-1:0]   rd_eff;
  logic                clr_edge;
  logic                drop;
  logic                clr_now;
  logic                clr_frees;

  logic [FullW-1:0]    addr_full;
  logic [P_ADDR_W-1:0] wr_addr;

  assign addr_full = {wr_pg_num, {P_PG_WORDS_LOG2{1'b0}}};

  generate
    if (P_ADDR_W > FullW) begin : g_addr_pad
      assign wr_addr = {{(P_ADDR_W - FullW){1'b0}}, addr_full};
    end else begin : g_addr_trunc
      assign wr_addr = addr_full[P_ADDR_W-1:0];
    end
  endgenerate

  always_comb begin
    wr_nxt = (wr_pg_num == last_pg) ? first_pg : wr_pg_num + PgOne;
    rd_nxt = (rd_pg_num == last_pg) ? first_pg : rd_pg_num + PgOne;

    if (full) begin
      n_used = n_alloc_q;
    end else if (wr_pg_num == rd_pg_num) begin
      n_used = '0;
    end else if (wr_pg_num > rd_pg_num) begin
      n_used = wr_pg_num - rd_pg_num;
    end else begin
      n_used = n_alloc_q + wr_pg_num - rd_pg_num;
    end

    // Clipping to n_used keeps the sum below 2*n_alloc, so one conditional subtract wraps it.
    cnt_clip = (pg_clr_cnt > n_used) ? n_used : pg_clr_cnt;
    rd_off   = rd_pg_num - first_pg;
    clr_sum  = {1'b0, rd_off} + {1'b0, cnt_clip};
    clr_wrap = (clr_sum >= {1'b0, n_alloc_q}) ? clr_sum - {1'b0, n_alloc_q} : clr_sum;
    rd_clr   = first_pg + clr_wrap[P_PG_W-1:0];
  end

  assign clr_edge  = pg_clr_req && !clr_req_q && !pg_clr_ack;
  assign drop      = (state_q == StFull) && overwrite && pg_ready;
  // A drop owns the read pointer this cycle; a coincident clear waits one cycle.
  assign clr_now   = (clr_edge || clr_pend_q) && !drop;
  assign clr_frees = clr_now && (cnt_clip != '0);
  assign rd_eff    = clr_now ? rd_clr : rd_pg_num;

  assign empty = !en || (!rst && (rd_pg_num == wr_pg_num) && !full);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_q    <= StIdle;
      en_q       <= 1'b0;
      clr_req_q  <= 1'b0;
      clr_pend_q <= 1'b0;
      n_alloc_q  <= '0;
      first_pg   <= '0;
      last_pg    <= '0;
      rd_pg_num  <= '0;
      wr_pg_num  <= '0;
      full       <= 1'b0;
      cfg_err    <= 1'b0;
      pg_req     <= 1'b0;
      pg_done    <= 1'b0;
      pg_addr    <= '0;
      pg_clr_ack <= 1'b0;
      n_used_pgs <= '0;
      hwm_flag   <= 1'b0;
      n_dropped  <= '0;
    end else if (!en_q) begin
      // Enable rising edge: latch bounds and start from an empty ring.
      state_q    <= StIdle;
      en_q       <= 1'b1;
      clr_req_q  <= pg_clr_req;
      clr_pend_q <= 1'b0;
      n_alloc_q  <= stop_pg - start_pg + PgOne;
      first_pg   <= start_pg;
      last_pg    <= stop_pg;
      rd_pg_num  <= start_pg;
      wr_pg_num  <= start_pg;
      full       <= 1'b0;
      cfg_err    <= (stop_pg < start_pg);
      pg_req     <= 1'b0;
      pg_done    <= 1'b0;
      pg_addr    <= '0;
      pg_clr_ack <= pg_clr_req;
      n_used_pgs <= '0;
      hwm_flag   <= 1'b0;
      n_dropped  <= '0;
    end else begin
      clr_req_q  <= pg_clr_req;
      pg_done    <= 1'b0;
      n_used_pgs <= n_used;
      hwm_flag   <= (n_used >= hwm);

      if (clr_edge && drop) begin
        clr_pend_q <= 1'b1;
      end else if (clr_now) begin
        clr_pend_q <= 1'b0;
      end

      if (clr_now) begin
        pg_clr_ack <= 1'b1;
        rd_pg_num  <= rd_clr;
        if (clr_frees) begin
          full <= 1'b0;
        end
      end else if (!pg_clr_req) begin
        pg_clr_ack <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (!cfg_err && pg_ready && !full) begin
            state_q <= StReq;
            pg_req  <= 1'b1;
            pg_addr <= wr_addr;
          end
        end
        StReq: begin
          if (pg_ack) begin
            state_q <= StAckLowWait;
            pg_req  <= 1'b0;
            pg_done <= 1'b1;
          end
        end
        StAckLowWait: begin
          if (!pg_ack) begin
            state_q <= StAdv;
          end
        end
        StAdv: begin
          wr_pg_num <= wr_nxt;
          if (wr_nxt == rd_eff) begin
            full    <= 1'b1;
            state_q <= StFull;
          end else begin
            full    <= 1'b0;
            state_q <= StIdle;
          end
        end
        StFull: begin
          if (drop) begin
            rd_pg_num <= rd_nxt;
            full      <= 1'b0;
            if (n_dropped != 32'hFFFF_FFFF) begin
              n_dropped <= n_dropped + 32'd1;
            end
            state_q <= StReq;
            pg_req  <= 1'b1;
            pg_addr <= wr_addr;
          end else if (clr_frees) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hbuf_ring_ctrl.sv
// Bench for hbuf_ring_ctrl: directed ring scenarios plus randomized page/clear traffic
// checked against a page-count ring model.
module tb_hbuf_ring_ctrl;

  localparam int PgW = 16;
  localparam int Wl  = 11;
  localparam int Aw  = 28;

  logic           clk = 1'b0;
  logic           rst, en, overwrite, pg_ready, pg_ack, pg_clr_req;
  logic [PgW-1:0] start_pg, stop_pg, hwm, pg_clr_cnt;
  logic           pg_done, pg_req, pg_clr_ack, empty, full, hwm_flag, cfg_err;
  logic [Aw-1:0]  pg_addr;
  logic [PgW-1:0] rd_pg_num, wr_pg_num, n_used_pgs, first_pg, last_pg;
  logic [31:0]    n_dropped;

  hbuf_ring_ctrl #(.P_PG_W(PgW), .P_PG_WORDS_LOG2(Wl), .P_ADDR_W(Aw)) dut (
    .clk(clk), .rst(rst), .en(en), .start_pg(start_pg), .stop_pg(stop_pg),
    .overwrite(overwrite), .hwm(hwm), .pg_ready(pg_ready), .pg_done(pg_done),
    .pg_req(pg_req), .pg_ack(pg_ack), .pg_addr(pg_addr), .pg_clr_req(pg_clr_req),
    .pg_clr_cnt(pg_clr_cnt), .pg_clr_ack(pg_clr_ack), .rd_pg_num(rd_pg_num),
    .wr_pg_num(wr_pg_num), .n_used_pgs(n_used_pgs), .empty(empty), .full(full),
    .hwm_flag(hwm_flag), .n_dropped(n_dropped), .cfg_err(cfg_err),
    .first_pg(first_pg), .last_pg(last_pg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Ring model: occupancy count and read offset within the latched bounds.
  int m_first, m_n, m_occ, m_rdoff, m_drops;

  function automatic void m_reset(input int first, input int n);
    m_first = first; m_n = n; m_occ = 0; m_rdoff = 0; m_drops = 0;
  endfunction

  function automatic int m_rd();
    return m_first + m_rdoff;
  endfunction

  function automatic int m_wr();
    return m_first + (m_rdoff + m_occ) % m_n;
  endfunction

  function automatic void m_write();
    if (m_occ == m_n) begin
      m_rdoff = (m_rdoff + 1) % m_n;
      m_drops++;
    end else begin
      m_occ++;
    end
  endfunction

  function automatic void m_clear(input int cnt);
    int c;
    c = (cnt > m_occ) ? m_occ : cnt;
    m_rdoff = (m_rdoff + c) % m_n;
    m_occ -= c;
  endfunction

  function automatic logic [Aw-1:0] addr_of(input int pg);
    logic [Aw-1:0] a;
    a = Aw'(pg);
    return a << Wl;
  endfunction

  task automatic enable_ring(input int s, input int e);
    en = 1'b0;
    @(negedge clk);
    start_pg = PgW'(s);
    stop_pg  = PgW'(e);
    en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Acts as the page writer and DDR3 side for one page.
  task automatic do_page(input int dly, output logic [Aw-1:0] addr, output bit ok,
                         output int dones);
    ok = 1'b0; dones = 0; addr = '0;
    pg_ready = 1'b1;
    for (int t = 0; t < 30 && !pg_req; t++) @(negedge clk);
    if (!pg_req) begin
      pg_ready = 1'b0;
      return;
    end
    addr = pg_addr;
    repeat (dly) @(negedge clk);
    pg_ack = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (pg_done) begin
        dones++;
        pg_ready = 1'b0;
      end
    end
    pg_ready = 1'b0;
    pg_ack = 1'b0;
    repeat (4) @(negedge clk);
    ok = (dones == 1);
  endtask

  task automatic do_clear(input int cnt, output bit ok);
    ok = 1'b0;
    pg_clr_cnt = PgW'(cnt);
    pg_clr_req = 1'b1;
    for (int t = 0; t < 10 && !pg_clr_ack; t++) @(negedge clk);
    if (!pg_clr_ack) begin
      pg_clr_req = 1'b0;
      return;
    end
    pg_clr_req = 1'b0;
    for (int t = 0; t < 10 && pg_clr_ack; t++) @(negedge clk);
    ok = !pg_clr_ack;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; overwrite = 1'b0; pg_ready = 1'b0; pg_ack = 1'b0;
    pg_clr_req = 1'b0; pg_clr_cnt = '0; start_pg = 16'd3; stop_pg = 16'd9; hwm = 16'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++;
    if (pg_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", pg_req); end
    checks++;
    if (wr_pg_num !== 16'd0) begin errors++; $display("FAIL reset_wr got=%0d exp=0", wr_pg_num); end
    checks++;
    if (first_pg !== 16'd0) begin errors++; $display("FAIL reset_first got=%0d exp=0", first_pg); end
    en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rd_pg_num !== 16'd0 || hwm_flag !== 1'b0 || pg_clr_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_rst_prio rd=%0d hwm_flag=%0b ack=%0b exp=0,0,0",
               rd_pg_num, hwm_flag, pg_clr_ack);
    end
    rst = 1'b0; en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    logic [Aw-1:0] addr;
    bit ok;
    int dones;
    overwrite = 1'b0; hwm = 16'd100;
    enable_ring(10, 13);
    for (int i = 0; i < 4; i++) begin
      do_page(1, addr, ok, dones);
      checks++;
      if (!ok || addr !== addr_of(10 + i)) begin
        errors++;
        $display("FAIL fill_addr%0d got=%h ok=%0b exp=%h", i, addr, ok, addr_of(10 + i));
      end
    end
    checks++;
    if (wr_pg_num !== 16'd10) begin errors++; $display("FAIL fill_wr got=%0d exp=10", wr_pg_num); end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%0b exp=1", full); end
    checks++;
    if (n_used_pgs !== 16'd4) begin errors++; $display("FAIL fill_used got=%0d exp=4", n_used_pgs); end
  endtask

  task automatic test_stall_clear();
    logic [Aw-1:0] addr;
    bit ok;
    int dones, seen;
    seen = 0;
    pg_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (pg_req) seen++;
    end
    pg_ready = 1'b0;
    checks++;
    if (seen != 0) begin errors++; $display("FAIL stall_req got=%0d exp=0", seen); end
    do_clear(1, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || rd_pg_num !== 16'd11 || full !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear ok=%0b rd=%0d full=%0b exp=1,11,0", ok, rd_pg_num, full);
    end
    do_page(0, addr, ok, dones);
    checks++;
    if (!ok || addr !== 28'h5000 || full !== 1'b1) begin
      errors++;
      $display("FAIL stall_refill ok=%0b addr=%h full=%0b exp=1,5000,1", ok, addr, full);
    end
  endtask

  task automatic test_overwrite();
    logic [Aw-1:0] addr;
    bit ok;
    int dones, total;
    total = 0;
    overwrite = 1'b1;
    enable_ring(10, 13);
    for (int i = 0; i < 4; i++) do_page(0, addr, ok, dones);
    for (int i = 0; i < 3; i++) begin
      do_page(2, addr, ok, dones);
      total += dones;
      checks++;
      if (addr !== addr_of(10 + i)) begin
        errors++;
        $display("FAIL ovw_addr%0d got=%h exp=%h", i, addr, addr_of(10 + i));
      end
    end
    checks++;
    if (total != 3) begin errors++; $display("FAIL ovw_done got=%0d exp=3", total); end
    checks++;
    if (n_dropped !== 32'd3) begin errors++; $display("FAIL ovw_drop got=%0d exp=3", n_dropped); end
    checks++;
    if (rd_pg_num !== 16'd13 || wr_pg_num !== 16'd13 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovw_ptr rd=%0d wr=%0d full=%0b exp=13,13,1", rd_pg_num, wr_pg_num, full);
    end
  endtask

  task automatic test_drop_clear();
    logic [Aw-1:0] addr;
    bit ok;
    int dones;
    overwrite = 1'b1;
    enable_ring(10, 13);
    for (int i = 0; i < 4; i++) do_page(0, addr, ok, dones);
    pg_clr_cnt = 16'd2;
    pg_ready = 1'b1;
    pg_clr_req = 1'b1;
    @(negedge clk);
    checks++;
    if (pg_req !== 1'b1 || pg_clr_ack !== 1'b0 || rd_pg_num !== 16'd11) begin
      errors++;
      $display("FAIL dropclr_first req=%0b ack=%0b rd=%0d exp=1,0,11",
               pg_req, pg_clr_ack, rd_pg_num);
    end
    addr = pg_addr;
    @(negedge clk);
    checks++;
    if (pg_clr_ack !== 1'b1 || rd_pg_num !== 16'd13) begin
      errors++;
      $display("FAIL dropclr_pend ack=%0b rd=%0d exp=1,13", pg_clr_ack, rd_pg_num);
    end
    pg_clr_req = 1'b0;
    pg_ack = 1'b1;
    @(negedge clk);
    pg_ready = 1'b0;
    pg_ack = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (addr !== 28'h5000 || wr_pg_num !== 16'd11 || full !== 1'b0 || n_used_pgs !== 16'd2 ||
        n_dropped !== 32'd1) begin
      errors++;
      $display("FAIL dropclr_end addr=%h wr=%0d full=%0b used=%0d drop=%0d exp=5000,11,0,2,1",
               addr, wr_pg_num, full, n_used_pgs, n_dropped);
    end
  endtask

  task automatic test_clear_all();
    logic [Aw-1:0] addr;
    bit ok;
    int dones;
    overwrite = 1'b0;
    enable_ring(10, 13);
    for (int i = 0; i < 4; i++) do_page(0, addr, ok, dones);
    pg_clr_cnt = 16'd9;
    pg_clr_req = 1'b1;
    for (int t = 0; t < 10 && !pg_clr_ack; t++) @(negedge clk);
    checks++;
    if (pg_clr_ack !== 1'b1 || rd_pg_num !== 16'd10 || empty !== 1'b1 || full !== 1'b0 ||
        n_used_pgs !== 16'd4) begin
      errors++;
      $display("FAIL clrall_ack ack=%0b rd=%0d empty=%0b full=%0b used=%0d exp=1,10,1,0,4",
               pg_clr_ack, rd_pg_num, empty, full, n_used_pgs);
    end
    @(negedge clk);
    checks++;
    if (n_used_pgs !== 16'd0) begin
      errors++; $display("FAIL clrall_used got=%0d exp=0", n_used_pgs);
    end
    pg_clr_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cfg_err();
    logic [Aw-1:0] addr;
    bit ok;
    int dones, seen;
    seen = 0;
    overwrite = 1'b0;
    enable_ring(20, 5);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err got=%0b exp=1", cfg_err); end
    pg_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (pg_req) seen++;
    end
    pg_ready = 1'b0;
    checks++;
    if (seen != 0) begin errors++; $display("FAIL cfg_req got=%0d exp=0", seen); end
    enable_ring(20, 20);
    do_page(1, addr, ok, dones);
    repeat (2) @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0 || !ok || addr !== 28'hA000 || full !== 1'b1 ||
        n_used_pgs !== 16'd1) begin
      errors++;
      $display("FAIL cfg_single err=%0b ok=%0b addr=%h full=%0b used=%0d exp=0,1,a000,1,1",
               cfg_err, ok, addr, full, n_used_pgs);
    end
  endtask

  task automatic test_clr_at_enable();
    en = 1'b0;
    @(negedge clk);
    start_pg = 16'd4; stop_pg = 16'd7;
    pg_clr_cnt = 16'd3;
    pg_clr_req = 1'b1;
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (pg_clr_ack !== 1'b1 || rd_pg_num !== 16'd4) begin
      errors++;
      $display("FAIL enclr_ack ack=%0b rd=%0d exp=1,4", pg_clr_ack, rd_pg_num);
    end
    pg_clr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (pg_clr_ack !== 1'b0) begin errors++; $display("FAIL enclr_drop got=%0b exp=0", pg_clr_ack); end
  endtask

  task automatic test_hwm();
    logic [Aw-1:0] addr;
    bit ok, found;
    int dones;
    overwrite = 1'b0;
    hwm = 16'd3;
    enable_ring(0, 7);
    do_page(0, addr, ok, dones);
    do_page(1, addr, ok, dones);
    pg_ready = 1'b1;
    for (int t = 0; t < 20 && !pg_req; t++) @(negedge clk);
    pg_ack = 1'b1;
    for (int t = 0; t < 10 && !pg_done; t++) @(negedge clk);
    pg_ready = 1'b0;
    pg_ack = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk);
      if (wr_pg_num == 16'd3) found = 1'b1;
    end
    checks++;
    if (!found || hwm_flag !== 1'b0 || n_used_pgs !== 16'd2) begin
      errors++;
      $display("FAIL hwm_lag found=%0b flag=%0b used=%0d exp=1,0,2", found, hwm_flag, n_used_pgs);
    end
    @(negedge clk);
    checks++;
    if (hwm_flag !== 1'b1 || n_used_pgs !== 16'd3) begin
      errors++;
      $display("FAIL hwm_set flag=%0b used=%0d exp=1,3", hwm_flag, n_used_pgs);
    end
    pg_ready = 1'b1;
    for (int t = 0; t < 20 && !pg_req; t++) @(negedge clk);
    checks++;
    if (pg_req !== 1'b1) begin errors++; $display("FAIL hwm_req got=%0b exp=1", pg_req); end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (pg_req !== 1'b0 || n_used_pgs !== 16'd0 || wr_pg_num !== 16'd0 || empty !== 1'b1 ||
        hwm_flag !== 1'b0) begin
      errors++;
      $display("FAIL hwm_disable req=%0b used=%0d wr=%0d empty=%0b flag=%0b exp=0,0,0,1,0",
               pg_req, n_used_pgs, wr_pg_num, empty, hwm_flag);
    end
    pg_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [Aw-1:0] addr;
    bit ok;
    int dones, s, n, kind, cnt, seen, exp_pg;
    for (int cfg = 0; cfg < 4; cfg++) begin
      s = $urandom_range(0, 40);
      n = $urandom_range(1, 6);
      overwrite = (cfg % 2 == 1);
      hwm = PgW'($urandom_range(1, n));
      enable_ring(s, s + n - 1);
      m_reset(s, n);
      for (int op = 0; op < 30; op++) begin
        kind = $urandom_range(0, 2);
        if (kind < 2 && m_occ == m_n && !overwrite) begin
          seen = 0;
          pg_ready = 1'b1;
          repeat (8) begin
            @(negedge clk);
            if (pg_req) seen++;
          end
          pg_ready = 1'b0;
          checks++;
          if (seen != 0) begin errors++; $display("FAIL rnd_stall got=%0d exp=0", seen); end
        end else if (kind < 2) begin
          exp_pg = m_wr();
          do_page($urandom_range(0, 3), addr, ok, dones);
          checks++;
          if (!ok || addr !== addr_of(exp_pg)) begin
            errors++;
            $display("FAIL rnd_page ok=%0b addr=%h exp=%h", ok, addr, addr_of(exp_pg));
          end
          m_write();
        end else begin
          cnt = $urandom_range(0, n + 2);
          do_clear(cnt, ok);
          checks++;
          if (!ok) begin errors++; $display("FAIL rnd_clr_hs got=0 exp=1"); end
          m_clear(cnt);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rd_pg_num !== PgW'(m_rd()) || wr_pg_num !== PgW'(m_wr())) begin
          errors++;
          $display("FAIL rnd_ptr rd=%0d wr=%0d exp=%0d,%0d", rd_pg_num, wr_pg_num, m_rd(), m_wr());
        end
        checks++;
        if (full !== (m_occ == m_n) || empty !== (m_occ == 0) ||
            n_used_pgs !== PgW'(m_occ)) begin
          errors++;
          $display("FAIL rnd_status full=%0b empty=%0b used=%0d exp_used=%0d",
                   full, empty, n_used_pgs, m_occ);
        end
        checks++;
        if (hwm_flag !== (m_occ >= int'(hwm)) || n_dropped !== 32'(m_drops)) begin
          errors++;
          $display("FAIL rnd_flags flag=%0b drop=%0d exp_used=%0d hwm=%0d exp_drop=%0d",
                   hwm_flag, n_dropped, m_occ, hwm, m_drops);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall_clear();
    test_overwrite();
    test_drop_clear();
    test_clear_all();
    test_cfg_err();
    test_clr_at_enable();
    test_hwm();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
